// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder inputs and decoded outputs of quad_decoder.
// QDEC_ERR_CNT_EN adds the err_cnt signal.
interface quad_decoder_if;
  logic a_in;
  logic b_in;
  logic step;
  logic updown;
  logic err;
  logic [1:0] ab_state;
`ifdef QDEC_ERR_CNT_EN
  logic [7:0] err_cnt;
  modport master (input a_in, b_in, output step, updown, err, ab_state, err_cnt);
  modport slave (output a_in, b_in, input step, updown, err, ab_state, err_cnt);
`else
  modport master (input a_in, b_in, output step, updown, err, ab_state);
  modport slave (output a_in, b_in, input step, updown, err, ab_state);
`endif
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: synchronise, glitch-filter and x4-decode quadrature A/B into step/updown/err.
// QDEC_ERR_CNT_EN adds a saturating 8-bit illegal-transition counter on err_cnt.
module quad_decoder #(
  parameter int FILT_LEN = 4
) (
  input logic clk,
  input logic rst,
  quad_decoder_if.master bus
);
  typedef enum logic {SETTLE, RUN} state_t;
  localparam logic [3:0] filt_last = 4'(FILT_LEN - 1);
  localparam logic [4:0] settle_last = 5'(FILT_LEN + 1);
  state_t state, state_nxt;
  logic [4:0] scnt, scnt_nxt;
  logic [1:0] sync1, sync2, filt, filt_nxt, ab_d;
  logic [3:0] fcnt [2];
  logic [3:0] fcnt_nxt [2];
  logic [1:0] idx_new, idx_old, diff;
  logic step_nxt, err_nxt, updown_nxt;
  logic step_r, err_r, updown_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLE;
      scnt <= '0;
    end else begin
      state <= state_nxt;
      scnt <= scnt_nxt;
    end
  end
  always_comb begin
    state_nxt = (state == SETTLE && scnt == settle_last) ? RUN : state;
    scnt_nxt = (state == SETTLE) ? scnt + 5'd1 : scnt;
  end
  // Bits 1/0 are channels A/B; settle copies the synchronised level straight through.
  always_comb begin
    filt_nxt = filt;
    fcnt_nxt = fcnt;
    for (int i = 0; i < 2; i++) begin
      fcnt_nxt[i] = (state == SETTLE || sync2[i] == filt[i] || fcnt[i] == filt_last) ? 4'd0 : fcnt[i] + 4'd1;
      filt_nxt[i] = (state == SETTLE || (sync2[i] != filt[i] && fcnt[i] == filt_last)) ? sync2[i] : filt[i];
    end
  end
  // Map Gray {A,B} onto a 0..3 up-count position; position delta gives the event.
  always_comb begin
    idx_new = {filt[0], filt[1] ^ filt[0]};
    idx_old = {ab_d[0], ab_d[1] ^ ab_d[0]};
    diff = idx_new - idx_old;
    step_nxt = state == RUN && diff[0];
    err_nxt = state == RUN && diff == 2'd2;
    updown_nxt = step_nxt ? diff == 2'd1 : updown_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      filt <= '0;
      ab_d <= '0;
      fcnt <= '{default: '0};
      step_r <= 1'b0;
      err_r <= 1'b0;
      updown_r <= 1'b1;
    end else begin
      sync1 <= {bus.a_in, bus.b_in};
      sync2 <= sync1;
      filt <= filt_nxt;
      ab_d <= (state == SETTLE) ? sync2 : filt;
      fcnt <= fcnt_nxt;
      step_r <= step_nxt;
      err_r <= err_nxt;
      updown_r <= updown_nxt;
    end
  end
  assign bus.step = step_r;
  assign bus.err = err_r;
  assign bus.updown = updown_r;
  assign bus.ab_state = filt;
`ifdef QDEC_ERR_CNT_EN
  logic [7:0] err_cnt;
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (err_r && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
  end
  assign bus.err_cnt = err_cnt;
`endif
endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature-encoder front end feeding the up/down counter stage. Samples raw asynchronous A/B encoder channels, synchronises and glitch-filters them, decodes the 2-bit Gray sequence at x4 resolution, and emits one-cycle `step` pulses with a registered `updown` direction. Downstream, `step` gates the counter's count enable and `updown` drives its mode select (1 = up). Illegal double-bit transitions are flagged rather than counted.

## Interface
- `FILT_LEN`, default 4: consecutive stable cycles (after synchronisation) required before a channel change is accepted; legal range 1–15.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a_in` input 1: encoder channel A, asynchronous.
- `b_in` input 1: encoder channel B, asynchronous.
- `step` output 1: one-cycle pulse per legal quadrature transition.
- `updown` output 1: direction of the most recent legal transition (1 = up, 0 = down).
- `err` output 1: one-cycle pulse per illegal transition (both filtered bits change together).
- `ab_state` output 2: filtered `{A,B}`.
- `err_cnt` output 8: saturating illegal-transition count; present only with `QDEC_ERR_CNT_EN`.

## Operation
- **Synchroniser:** each channel passes through a 2-FF synchroniser. The second stage is `a_s`/`b_s`.
- **Filter:** a per-channel 4-bit counter increments each cycle the sync value differs from the filtered value.
  - The counter clears on any cycle they match.
  - When the counter reaches `FILT_LEN-1` while still differing, the filtered bit takes the sync value at the next edge and the counter clears.
  - Channels filter independently, so both bits may update on the same edge.
- **Decode:** compare the new filtered `{A,B}` with the previous value.
  - Up sequence: 00→10→11→01→00. Each step pulses `step` and sets `updown`=1.
  - Down sequence: the reverse, 00→01→11→10→00. Each step pulses `step` and sets `updown`=0.
  - No change: `step`=0, `err`=0, `updown` holds.
  - Both bits changed (00↔11, 10↔01): `err`=1, `step`=0, `updown` holds. `ab_state` still adopts the new value, so decoding resumes from it.
- **Settle window:**
  - States: SETTLE then RUN.
  - For the first `FILT_LEN+2` cycles after `rst` deasserts, the FSM is in SETTLE. The filtered bits copy `a_s`/`b_s` every cycle (filter bypassed), and `step`/`err` are forced 0.
  - The FSM then enters RUN and stays there until the next `rst`.
- **Reset values:** `step`=0, `err`=0, `updown`=1, `ab_state`=00, synchroniser and filter counters 0, FSM=SETTLE, `err_cnt`=0.
- **Reset mid-operation:** an asserted `rst` overrides everything on that edge. Any pending filter count is discarded, and no `step`/`err` is issued on or during reset.

## Timing
- Edge 0 is the first edge sampling a new, stable level on a channel.
  - `a_s` shows the level after edge 1.
  - The filtered bit updates at edge `1+FILT_LEN`.
  - `step`/`err`/`updown` register at edge `2+FILT_LEN`.
  - Total latency is `FILT_LEN+2` cycles; `ab_state` leads `step` by one cycle.
- A level held at `a_s` for fewer than `FILT_LEN` cycles is rejected with no output activity.
- Maximum accepted transition rate is one per `FILT_LEN` cycles per channel. Faster inputs are filtered out or produce `err`.
- `step` and `err` are never high in the same cycle. Each is high for exactly one cycle per event, and back-to-back events give back-to-back pulses.

## Configuration
- `QDEC_ERR_CNT_EN` defined:
  - adds the `err_cnt` port and an 8-bit counter;
  - the counter increments on each `err` pulse and saturates at 255 (no wrap);
  - cleared only by `rst`.
- `QDEC_ERR_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset with inputs at 11:** hold `a_in`=`b_in`=1 through reset, release, wait 10 cycles → `ab_state`=11, `step` and `err` never pulse, `updown`=1.
- **Full up cycle:** `FILT_LEN`=4, drive 00→10→11→01→00, each level held 20 cycles → exactly 4 `step` pulses, each 6 cycles after its input edge, `updown`=1, `err`=0.
- **Down then reverse:** drive 00→01→11 (down), then 11→01 (up) → 2 steps with `updown`=0, then 1 step with `updown`=1 registered in the same cycle as that step.
- **Glitch rejection:** 3-cycle pulse on `a_in` with `FILT_LEN`=4 → no `step`, no `err`, `ab_state` unchanged. Repeat with a 4-cycle pulse → 2 steps (up, then down).
- **Illegal jump:** change both inputs 00→11 on the same edge → one `err` pulse, no `step`, `updown` holds. With `QDEC_ERR_CNT_EN`, 300 such jumps → `err_cnt`=255.
- **Reset mid-filter:** assert `rst` 2 cycles into a pending `a_in` change → no `step` during or after reset, all outputs at reset values, then SETTLE lasts `FILT_LEN+2` cycles before the first step is accepted.
